// File: rtl/program_loader_pkg.sv
// Shared instruction-set definitions used by the program loader and its
// byte assembler: word geometry, instruction class codes and loader states.
package program_loader_pkg;

  localparam int INST_WIDTH = 24;
  localparam int BYTE_WIDTH = 8;
  localparam int CLASS_MSB  = 23;
  localparam int CLASS_LSB  = 22;

  typedef enum logic [1:0] {
    CLASS_ALU   = 2'b00,
    CLASS_CONST = 2'b01,
    CLASS_MEM   = 2'b10,
    CLASS_CTRL  = 2'b11
  } instClass_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RECV  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } loaderState_t;

  // Extract the instruction class field from a full instruction word.
  function automatic instClass_t instClass(input logic [INST_WIDTH-1:0] word);
    return instClass_t'(word[CLASS_MSB:CLASS_LSB]);
  endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs three host bytes, most significant first, into one instruction word.
// The word register is updated in place so each byte lands in its final slot.
module program_loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic [INST_WIDTH-1:0] o_word,
  output logic                  o_word_ready
);

  logic [INST_WIDTH-1:0] r_word;
  logic [1:0]            r_byteIdx;

  // The third accepted byte completes the word in the same cycle it is taken.
  assign o_word_ready = i_accept && (r_byteIdx == 2'd2);
  assign o_word       = r_word;

  // Steer each accepted byte into its slot and advance the byte index.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word    <= '0;
      r_byteIdx <= 2'd0;
    end else if (i_clear) begin
      r_byteIdx <= 2'd0;
    end else if (i_accept) begin
      case (r_byteIdx)
        2'd0: begin
          r_word[INST_WIDTH-1 -: BYTE_WIDTH] <= i_byte;
          r_byteIdx <= 2'd1;
        end
        2'd1: begin
          r_word[INST_WIDTH-BYTE_WIDTH-1 -: BYTE_WIDTH] <= i_byte;
          r_byteIdx <= 2'd2;
        end
        2'd2: begin
          r_word[BYTE_WIDTH-1:0] <= i_byte;
          r_byteIdx <= 2'd0;
        end
        default: r_byteIdx <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Writer side of the instruction memory: takes a host byte stream, builds
// 24-bit words, writes them to consecutive addresses while holding the CPU,
// and keeps saturating per-class counts of the words written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
)
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH:0]     i_n_inst,
  input  logic                    i_byte_valid,
  input  logic [BYTE_WIDTH-1:0]   i_byte_data,
  output logic                    o_byte_ready,
  output logic [ADDR_WIDTH-1:0]   o_inst_addr,
  output logic [INST_WIDTH-1:0]   o_inst_data,
  output logic                    o_write_inst,
  output logic                    o_cpu_hold,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*CNT_WIDTH-1:0]  o_class_cnt
);

  localparam logic [ADDR_WIDTH:0] MAX_INST = {1'b1, {ADDR_WIDTH{1'b0}}};

  loaderState_t          r_state;
  logic [ADDR_WIDTH:0]   r_nInst;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_byteReady;
  logic                  r_writeInst;
  logic                  r_cpuHold;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_classCnt [4];

  logic                  w_start;
  logic                  w_accept;
  logic                  w_wordReady;
  logic [INST_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH:0]   w_nSat;
  logic                  w_lastWord;
  instClass_t            w_class;

  assign w_start    = (r_state == ST_IDLE) && i_start;
  assign w_accept   = (r_state == ST_RECV) && i_byte_valid && r_byteReady;
  assign w_nSat     = (i_n_inst > MAX_INST) ? MAX_INST : i_n_inst;
  assign w_lastWord = ({1'b0, r_addr} == (r_nInst - (ADDR_WIDTH+1)'(1)));
  assign w_class    = instClass(w_word);

  program_loader_byte_assembler u_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_start),
    .i_accept     (w_accept),
    .i_byte       (i_byte_data),
    .o_word       (w_word),
    .o_word_ready (w_wordReady)
  );

  assign o_byte_ready = r_byteReady;
  assign o_inst_addr  = r_addr;
  assign o_inst_data  = w_word;
  assign o_write_inst = r_writeInst;
  assign o_cpu_hold   = r_cpuHold;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_class_cnt  = {r_classCnt[CLASS_CTRL], r_classCnt[CLASS_MEM],
                         r_classCnt[CLASS_CONST], r_classCnt[CLASS_ALU]};

  // Loader FSM; outputs are registered to match the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_nInst     <= '0;
      r_addr      <= '0;
      r_byteReady <= 1'b0;
      r_writeInst <= 1'b0;
      r_cpuHold   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < 4; i++) r_classCnt[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_nInst <= w_nSat;
            r_addr  <= '0;
            for (int i = 0; i < 4; i++) r_classCnt[i] <= '0;
            if (w_nSat == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_RECV;
              r_byteReady <= 1'b1;
              r_busy      <= 1'b1;
              r_cpuHold   <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (w_wordReady) begin
            r_state     <= ST_WRITE;
            r_byteReady <= 1'b0;
            r_writeInst <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_writeInst <= 1'b0;
          if (r_classCnt[w_class] != '1)
            r_classCnt[w_class] <= r_classCnt[w_class] + CNT_WIDTH'(1);
          if (w_lastWord) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_cpuHold <= 1'b0;
          end else begin
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_state     <= ST_RECV;
            r_byteReady <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a small address space so that the
// full-memory and counter-saturation corners are reachable in a few cycles.
module tb_program_loader;

  localparam int AW      = 2;
  localparam int CW      = 2;
  localparam int MAXW    = 1 << AW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [AW:0]       nInst;
  logic              byteValid;
  logic [7:0]        byteData;
  logic              byteReady;
  logic [AW-1:0]     instAddr;
  logic [23:0]       instData;
  logic              writeInst;
  logic              cpuHold;
  logic              busy;
  logic              done;
  logic [4*CW-1:0]   classCnt;

  int checks   = 0;
  int failures = 0;

  int cycleCnt       = 0;
  int lastWriteCycle = 0;
  int doneCount      = 0;
  int doneCycle      = 0;
  int busyCycles     = 0;
  int holdErr        = 0;
  logic [1:0] doneBusyHold = 2'b00;
  bit inLoad = 1'b0;

  logic [AW-1:0] gotAddr [$];
  logic [23:0]   gotData [$];
  logic [23:0]   loadWords [$];

  always #5 clock = ~clock;

  program_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk        (clock),
    .i_reset      (reset),
    .i_start      (start),
    .i_n_inst     (nInst),
    .i_byte_valid (byteValid),
    .i_byte_data  (byteData),
    .o_byte_ready (byteReady),
    .o_inst_addr  (instAddr),
    .o_inst_data  (instData),
    .o_write_inst (writeInst),
    .o_cpu_hold   (cpuHold),
    .o_busy       (busy),
    .o_done       (done),
    .o_class_cnt  (classCnt)
  );

  // Free-running cycle number used to time writes and the done pulse.
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Passive monitor, sampling mid-cycle: records every write and done pulse.
  always @(negedge clock) begin
    if (writeInst) begin
      gotAddr.push_back(instAddr);
      gotData.push_back(instData);
      lastWriteCycle <= cycleCnt;
    end
    if (done) begin
      doneCount    <= doneCount + 1;
      doneCycle    <= cycleCnt;
      doneBusyHold <= {busy, cpuHold};
    end
    if (busy) busyCycles <= busyCycles + 1;
    if (inLoad && !done && !cpuHold) holdErr <= holdErr + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_addrData"}, {instAddr, instData}, '0);
    checkOutput({tag, "_classCnt"}, classCnt, '0);
    checkOutput({tag, "_flags"}, {byteReady, writeInst, cpuHold, busy, done}, '0);
  endtask

  // Expected class counts straight from the word list, saturated to the counter range.
  function automatic logic [4*CW-1:0] expectedCounts(input int nEff);
    int cnt [4];
    logic [4*CW-1:0] packed_;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int w = 0; w < nEff; w++) cnt[int'(loadWords[w][23:22])]++;
    packed_ = '0;
    for (int c = 0; c < 4; c++)
      packed_ = packed_ | ((4*CW)'(cnt[c] > CNT_MAX ? CNT_MAX : cnt[c]) << (CW*c));
    return packed_;
  endfunction

  // Run one load of loadWords with random byte gaps; optionally abort via reset.
  task automatic applyStimulus(input int nReq, input int gapPct,
                               input int abortAfter, input bit startNoise);
    int nEff, nBytes, idx, writeBase, doneBase, busyBase, holdBase, startCycle;
    logic [7:0] bytes [$];
    logic [23:0] w;
    bit willAccept;

    nEff   = (nReq > MAXW) ? MAXW : nReq;
    nBytes = 3 * nEff;
    for (int i = 0; i < nEff; i++) begin
      w = loadWords[i];
      bytes.push_back(w[23:16]);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
    end

    writeBase = gotAddr.size();
    doneBase  = doneCount;
    busyBase  = busyCycles;
    holdBase  = holdErr;

    startCycle = cycleCnt;
    start      = 1'b1;
    nInst      = nReq[AW:0];
    byteValid  = 1'b0;
    tick();
    start  = 1'b0;
    inLoad = (nEff > 0);

    idx = 0;
    for (int c = 0; c < 600 && idx < nBytes; c++) begin
      willAccept = 1'b0;
      if (byteReady && $urandom_range(0, 99) >= gapPct) begin
        byteValid  = 1'b1;
        byteData   = bytes[idx];
        willAccept = 1'b1;
      end else begin
        byteValid = byteReady ? 1'b0 : 1'($urandom_range(0, 1));
        byteData  = 8'($urandom);
      end
      start = startNoise && ($urandom_range(0, 9) == 0);
      nInst = (AW+1)'($urandom);
      tick();
      if (willAccept) idx++;
      if (abortAfter >= 0 && idx == abortAfter) break;
    end
    start     = 1'b0;
    byteValid = 1'b0;

    if (abortAfter >= 0) begin
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      inLoad = 1'b0;
      checkResetState("abortReset");
      writeBase = gotAddr.size();
      repeat (6) tick();
      checkOutput("noWriteAfterReset", 64'(gotAddr.size() - writeBase), 0);
      return;
    end

    checkOutput("bytesFed", 64'(idx), 64'(nBytes));

    for (int c = 0; c < 40 && doneCount == doneBase; c++) begin
      byteValid = byteReady ? 1'b0 : 1'($urandom_range(0, 1));
      byteData  = 8'($urandom);
      tick();
    end
    byteValid = 1'b0;
    inLoad    = 1'b0;

    // Offer a byte past the end of the load; it must not be taken.
    byteValid = 1'b1;
    byteData  = 8'($urandom);
    checkOutput("readyAfterDone", byteReady, 0);
    tick();
    tick();
    byteValid = 1'b0;
    tick();

    checkOutput("doneCount", 64'(doneCount - doneBase), 1);
    checkOutput("writeCount", 64'(gotAddr.size() - writeBase), 64'(nEff));
    for (int i = 0; i < nEff && writeBase + i < gotAddr.size(); i++) begin
      checkOutput($sformatf("addr%0d", i), gotAddr[writeBase+i], 64'(i));
      checkOutput($sformatf("data%0d", i), gotData[writeBase+i], loadWords[i]);
    end
    if (nEff > 0) begin
      checkOutput("doneAfterLastWrite", 64'(doneCycle), 64'(lastWriteCycle + 1));
      checkOutput("holdDuringLoad", 64'(holdErr - holdBase), 0);
    end else begin
      checkOutput("emptyDoneLatency", 64'(doneCycle), 64'(startCycle + 1));
      checkOutput("emptyNeverBusy", 64'(busyCycles - busyBase), 0);
    end
    checkOutput("doneBusyHold", doneBusyHold, 2'b00);
    checkOutput("classCnt", classCnt, expectedCounts(nEff));
  endtask

  // Watchdog so the run always ends even if the design wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed corners first, then a batch of randomized loads.
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    nInst     = '0;
    byteValid = 1'b0;
    byteData  = '0;
    tick();
    tick();
    checkResetState("initReset");
    reset = 1'b0;
    tick();

    $display("[TB] reset during load");
    loadWords = '{24'h123456, 24'hAB0000};
    applyStimulus(2, 0, 4, 1'b0);
    loadWords = '{24'h000001};
    applyStimulus(1, 0, -1, 1'b0);

    $display("[TB] class counting");
    loadWords = '{24'h0ABCDE, 24'h4FFFFF, 24'h800010, 24'hC00003};
    applyStimulus(4, 0, -1, 1'b0);

    $display("[TB] gapped byte stream");
    loadWords = '{24'h112233};
    applyStimulus(1, 50, -1, 1'b1);

    $display("[TB] empty load");
    loadWords.delete();
    applyStimulus(0, 0, -1, 1'b0);

    $display("[TB] full memory with saturated count");
    loadWords.delete();
    for (int i = 0; i < MAXW; i++) loadWords.push_back(24'($urandom));
    applyStimulus(5, 20, -1, 1'b1);

    $display("[TB] class counter saturation");
    loadWords.delete();
    for (int i = 0; i < MAXW; i++) loadWords.push_back({2'b11, 22'($urandom)});
    applyStimulus(MAXW, 0, -1, 1'b0);

    $display("[TB] randomized loads");
    for (int r = 0; r < 20; r++) begin
      loadWords.delete();
      for (int i = 0; i < MAXW; i++) loadWords.push_back(24'($urandom));
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 60), -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
